// File: rtl/dp_sync_ram.sv
// dp_sync_ram: simple-dual-port synchronous RAM.
// One write port with byte-lane enables and one read port, both usable in the
// same cycle. Reads have a registered latency of READ_LAT (1 or 2) cycles and
// come with a rd_valid strobe. Same-address read-during-write is write-first
// per lane. Out-of-range writes are dropped and out-of-range reads return 0.
//
// Handshake: a request (wr_en or rd_en) is accepted on a posedge only while
// ready=1; there is no back-pressure or queueing, and requests seen while
// ready=0 are dropped.
//
// Optional macro RAM_CLEAR_EN: adds a CLEAR/RUN FSM that zeroes the whole
// array after every reset and holds ready low until the sweep finishes.
module dp_sync_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int READ_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      ready
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             wr_in, rd_in;
    logic             wr_fire, rd_fire;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic             clr_we;
    logic [IDX_W-1:0] clr_ptr;

    assign wr_in   = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in   = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_idx  = wr_addr[IDX_W-1:0];
    assign rd_idx  = rd_addr[IDX_W-1:0];
    assign wr_fire = wr_en & ready & wr_in;
    assign rd_fire = rd_en & ready;

`ifdef RAM_CLEAR_EN
    typedef enum logic {CLEAR, RUN} clr_state_e;
    clr_state_e state_q, state_d;
    // Exposed for checkers: current clear FSM state.
    clr_state_e clr_state_dbg;
    assign clr_state_dbg = state_q;

    // Clear FSM state register; every reset restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLEAR;
        else        state_q <= state_d;
    end

    // Sweep pointer advances once per cycle while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                clr_ptr <= '0;
        else if (state_q == CLEAR) clr_ptr <= clr_ptr + IDX_W'(1);
    end

    // Next state: leave CLEAR once the last implemented word is zeroed.
    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr == IDX_W'(DEPTH - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    assign ready = (state_q == RUN);
`else
    assign clr_we  = 1'b0;
    assign clr_ptr = '0;
    assign ready   = 1'b1;
`endif

    // Array update: clear sweep has priority, otherwise per-lane write.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read word with write-first forwarding of enabled lanes; 0 if out of range.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[rd_idx];
            for (int i = 0; i < NB; i++) begin
                if (wr_fire && (wr_idx == rd_idx) && wr_be[i])
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // First read stage: capture the word; data holds when no read issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) s1_data <= rd_word;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;
            // Extra output register stage; holds data between results.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end
            assign rd_valid = s2_valid;
            assign rd_data  = s2_data;
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_dp_sync_ram.sv
// Testbench for dp_sync_ram: two instances (READ_LAT=1 and READ_LAT=2) share
// the same stimulus; DATA_WIDTH=16, ADDR_WIDTH=4, DEPTH=12.
// Build with +define+RAM_CLEAR_EN to exercise the clear sweep.
module tb_dp_sync_ram;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2;
    logic        ready1, ready2;

    int n_checks = 0;
    int n_errors = 0;

    dp_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .ready(ready1)
    );

    dp_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .ready(ready2)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    // Issue one read; check the 1-cycle instance, then the 2-cycle instance.
    task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        check({tag, "_v1"}, 32'(rd_valid1), 32'd1);
        check({tag, "_d1"}, 32'(rd_data1), 32'(exp));
        step();
        check({tag, "_v2"}, 32'(rd_valid2), 32'd1);
        check({tag, "_d2"}, 32'(rd_data2), 32'(exp));
    endtask

    task automatic count_not_ready(output int n);
        n = 0;
        while (!ready1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        count_not_ready(n);
        check({tag, "_ready"}, 32'(ready1 & ready2), 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        #12;
        check("rst_v1", 32'(rd_valid1), 32'd0);
        check("rst_d1", 32'(rd_data1), 32'd0);
        check("rst_v2", 32'(rd_valid2), 32'd0);
        check("rst_d2", 32'(rd_data2), 32'd0);
`ifdef RAM_CLEAR_EN
        check("rst_ready", 32'(ready1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Requests during the sweep must be ignored.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1111; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd3;
        n = 0; bad = 0;
        while (!ready1 && n < 100) begin
            step();
            n++;
            if (rd_valid1 || rd_valid2) bad++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("sweep_len", 32'(n), 32'd12);
        check("sweep_rd_ignored", 32'(bad), 32'd0);
        rd(4'd3, 16'h0000, "clr3");
        // Reset at sweep cycle 6 restarts the sweep.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("mid_sweep_ready", 32'(ready1), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_not_ready(n);
        check("resweep_len", 32'(n), 32'd12);
`else
        check("rst_ready", 32'(ready1 & ready2), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("run_ready", 32'(ready1 & ready2), 32'd1);
`endif

        // Basic read and hold
        wr(4'd3, 16'hBEEF, 2'b11);
        rd(4'd3, 16'hBEEF, "basic");
        check("hold_v1", 32'(rd_valid1), 32'd0);
        check("hold_d1", 32'(rd_data1), 32'h0000BEEF);
        step();
        check("hold_v2", 32'(rd_valid2), 32'd0);
        check("hold_d2", 32'(rd_data2), 32'h0000BEEF);

        // Byte lanes
        wr(4'd5, 16'h1234, 2'b11);
        wr(4'd5, 16'hABCD, 2'b10);
        rd(4'd5, 16'hAB34, "lane_hi");
        wr(4'd5, 16'hFFFF, 2'b00);
        rd(4'd5, 16'hAB34, "lane_none");

        // Read-during-write, same address: write-first per lane
        wr(4'd7, 16'h5555, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00FF; wr_be = 2'b01;
        rd_en = 1'b1; rd_addr = 4'd7;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw_same_v1", 32'(rd_valid1), 32'd1);
        check("rdw_same_d1", 32'(rd_data1), 32'h000055FF);
        step();
        check("rdw_same_d2", 32'(rd_data2), 32'h000055FF);
        // Different addresses do not interact
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h1357; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd7;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw_diff_d1", 32'(rd_data1), 32'h000055FF);
        step();
        check("rdw_diff_d2", 32'(rd_data2), 32'h000055FF);
        rd(4'd8, 16'h1357, "rdw_diff_wr");

        // Back-to-back reads, both latencies
        wr(4'd0, 16'h000A, 2'b11);
        wr(4'd1, 16'h000B, 2'b11);
        wr(4'd2, 16'h000C, 2'b11);
        rd_en = 1'b1; rd_addr = 4'd0;
        step();
        check("b2b_c1_v1", 32'(rd_valid1), 32'd1);
        check("b2b_c1_d1", 32'(rd_data1), 32'h0A);
        check("b2b_c1_v2", 32'(rd_valid2), 32'd0);
        rd_addr = 4'd1;
        step();
        check("b2b_c2_d1", 32'(rd_data1), 32'h0B);
        check("b2b_c2_v2", 32'(rd_valid2), 32'd1);
        check("b2b_c2_d2", 32'(rd_data2), 32'h0A);
        rd_addr = 4'd2;
        step();
        rd_en = 1'b0;
        check("b2b_c3_d1", 32'(rd_data1), 32'h0C);
        check("b2b_c3_v2", 32'(rd_valid2), 32'd1);
        check("b2b_c3_d2", 32'(rd_data2), 32'h0B);
        step();
        check("b2b_c4_v1", 32'(rd_valid1), 32'd0);
        check("b2b_c4_v2", 32'(rd_valid2), 32'd1);
        check("b2b_c4_d2", 32'(rd_data2), 32'h0C);
        step();
        check("b2b_c5_v2", 32'(rd_valid2), 32'd0);
        check("b2b_c5_d2", 32'(rd_data2), 32'h0C);

        // Out of range
        rd(4'd13, 16'h0000, "oor_rd13");
        wr(4'd14, 16'hDEAD, 2'b11);
        rd(4'd14, 16'h0000, "oor_rd14");
        rd(4'd2, 16'h000C, "oor_keep2");

        // Reset asserted between edges with a read in flight
        rd_en = 1'b1; rd_addr = 4'd3;
        @(posedge clk);
        #1;
        check("pre_rst_d1", 32'(rd_data1), 32'h0000BEEF);
        #1;
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        check("mid_rst_v1", 32'(rd_valid1), 32'd0);
        check("mid_rst_d1", 32'(rd_data1), 32'd0);
        check("mid_rst_v2", 32'(rd_valid2), 32'd0);
        check("mid_rst_d2", 32'(rd_data2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_v1a", 32'(rd_valid1), 32'd0);
        check("post_rst_v2a", 32'(rd_valid2), 32'd0);
        step();
        check("post_rst_v2b", 32'(rd_valid2), 32'd0);
`ifdef RAM_CLEAR_EN
        wait_ready("post_rst");
        rd(4'd3, 16'h0000, "post_rst_mem3");
`else
        rd(4'd3, 16'hBEEF, "post_rst_mem3");
`endif

        // Final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dp_sync_ram.md
Name: dp_sync_ram

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port, both usable in the same cycle.
- Next generation of the project's single-port sync RAM. Adds:
  - byte-lane write enables
  - configurable pipelined read latency with a valid strobe
  - defined read-during-write behaviour
  - reset, out-of-range handling and a ready indication
- Used as register-file / scratch / frame storage behind the datapath. Everything is on one clock edge; there is no tri-state data bus.

Parameters:
- ADDR_WIDTH, 10, address bits for both ports.
- DATA_WIDTH, 16, word width in bits. Must be a multiple of 8.
- DEPTH, 1<<ADDR_WIDTH, number of implemented words. Must be ≤ 1<<ADDR_WIDTH.
- READ_LAT, 1, read latency in cycles. Legal values are 1 or 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request, sampled on posedge.
- wr_addr  input  ADDR_WIDTH  write word address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  DATA_WIDTH/8  byte-lane enables; bit i covers data bits [8i+7:8i].
- rd_en  input  1  read request, sampled on posedge.
- rd_addr  input  ADDR_WIDTH  read word address.
- rd_data  output  DATA_WIDTH  read data, registered.
- rd_valid  output  1  one-cycle strobe; rd_data is valid for the read issued READ_LAT cycles earlier.
- ready  output  1  high when requests are accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data=0, rd_valid=0; read pipeline flushed.
  - ready=1 (macro off). With the macro on, ready=0 until the clear sweep completes.
  - Memory array has no reset; contents are retained across reset when the macro is off.
- Write: at posedge with wr_en & ready & (wr_addr < DEPTH), lane i of mem[wr_addr] is updated iff wr_be[i]=1.
  - wr_be=0 is a legal no-op.
  - Write with wr_addr ≥ DEPTH is silently dropped.
- Read: at posedge with rd_en & ready, rd_addr is captured.
  - Exactly READ_LAT posedges later: rd_valid=1 and rd_data=word.
  - Throughput is one read per cycle, back-to-back, with no bubbles.
  - READ_LAT=2 adds one output register stage.
  - rd_addr ≥ DEPTH: rd_valid still pulses and rd_data=0.
- rd_data holds its last value while rd_valid=0. rd_valid is high only in the result cycles.
- Read-during-write, same cycle and same in-range address: write-first, per lane.
  - Lanes with wr_be set return the new wr_data.
  - Other lanes return the old contents.
  - Different addresses do not interact.
- wr_en and rd_en are ignored while ready=0. No stall or queueing.
- Reset asserted mid-read: in-flight results are discarded; no rd_valid is emitted after rst_n rises for requests issued before reset.

Optional Feature:
- Macro: RAM_CLEAR_EN.
- Defined: a clear FSM with states CLEAR and RUN.
  - rst_n low → CLEAR, clear pointer=0, ready=0.
  - In CLEAR, each posedge writes 0 to mem[ptr] and increments ptr.
  - When ptr=DEPTH-1 has been written, the FSM moves to RUN and ready=1 on the following cycle. The sweep takes exactly DEPTH cycles after rst_n rises.
  - rst_n reasserted mid-sweep restarts the sweep from 0.
  - In RUN, behaviour is identical to the macro-off case.
- Not defined: no FSM. ready is tied 1 when out of reset, and contents after power-up are undefined (X in simulation).

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=4, DEPTH=12):
- Basic read, READ_LAT=1:
  - Write 0xBEEF to addr 3 with wr_be=2'b11.
  - Next cycle, read addr 3 → one cycle later rd_valid=1, rd_data=0xBEEF.
  - Following cycle rd_valid=0 and rd_data stays 0xBEEF.
- Byte lanes:
  - mem[5]=0x1234; write 0xABCD with wr_be=2'b10 → read 5 returns 0xAB34.
  - Write with wr_be=2'b00 → still 0xAB34.
- Read-during-write:
  - mem[7]=0x5555; same cycle, write 0x00FF with wr_be=2'b01 and read addr 7 → rd_data=0x55FF.
  - Same cycle, write addr 8 and read addr 7 → old mem[7].
- Latency and out-of-range, READ_LAT=2:
  - Back-to-back reads of addrs 0,1,2 (preloaded 0x0A,0x0B,0x0C) → rd_valid high for 3 consecutive cycles starting 2 cycles after the first request, data 0x0A,0x0B,0x0C.
  - Read addr 13 → rd_valid=1, rd_data=0.
  - Write addr 14 → no array change.
- Reset mid-flight: with a read in flight, pulse rst_n low asynchronously between edges → rd_valid=0 and rd_data=0 immediately; no stale rd_valid afterwards; mem[3] still 0xBEEF (macro off).
- RAM_CLEAR_EN:
  - After rst_n rises, ready=0 for exactly 12 cycles and then 1.
  - rd_en/wr_en during the sweep are ignored.
  - Read addr 3 afterwards → 0x0000.
  - Reset at sweep cycle 6 → ready stays 0 for a full 12 cycles after release.
